// File: rtl/div_share_ctrl_if.sv
// ============================================================================
// Module   : div_share_ctrl_if
// Purpose  : Start/done handshake and operand/result bus to the shared divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_share_ctrl_if;
   logic       div_start;
   logic [7:0] div_dividend;
   logic [7:0] div_divisor;
   logic       div_done;
   logic [7:0] div_quotient;
   logic [7:0] div_remainder;

   // Controller side drives start and operands; divider side returns results.
   modport master (
      output div_start,
      output div_dividend,
      output div_divisor,
      input  div_done,
      input  div_quotient,
      input  div_remainder
   );

   modport slave (
      input  div_start,
      input  div_dividend,
      input  div_divisor,
      output div_done,
      output div_quotient,
      output div_remainder
   );
endinterface

`default_nettype wire

// File: rtl/div_share_ctrl.sv
// ============================================================================
// Module   : div_share_ctrl
// Purpose  : Round-robin sharing of one sequential signed 8-bit divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_share_ctrl #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_dividend,
   input  logic [8*N_REQ-1:0]   req_divisor,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [7:0]           rsp_quotient,
   output logic [7:0]           rsp_remainder,
   output logic                 rsp_err,
   output logic                 busy,
   div_share_ctrl_if.master     div_bus
);

   localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int c_IW = c_PW + 1;
   localparam int c_WW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

   localparam logic [N_REQ-1:0] c_ONE      = N_REQ'(1);
   localparam logic [c_PW-1:0]  c_PTR_INIT = c_PW'(N_REQ - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;

   logic [c_PW-1:0]  r_ptr;
   logic [c_WW-1:0]  r_wdog;
   logic [7:0]       r_op_dividend;
   logic [7:0]       r_op_divisor;

   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] r_rsp_valid;
   logic [7:0]       r_rsp_q;
   logic [7:0]       r_rsp_r;
   logic             r_rsp_err;
   logic             r_busy;
   logic             r_start;

   logic [N_REQ-1:0] w_gnt_nxt;
   logic [N_REQ-1:0] w_rsp_valid_nxt;
   logic [7:0]       w_rsp_q_nxt;
   logic [7:0]       w_rsp_r_nxt;
   logic             w_rsp_err_nxt;
   logic             w_busy_nxt;
   logic             w_start_nxt;
   logic             w_ld_op;

   logic             w_any;
   logic [c_PW-1:0]  w_sel;
   logic [c_IW-1:0]  w_idx;
   logic             w_div0;
   logic             w_ovf;
   logic             w_wdog_exp;

   logic [7:0]       w_dvd [N_REQ];
   logic [7:0]       w_dvs [N_REQ];

   generate
      for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
         assign w_dvd[k] = req_dividend[8*k +: 8];
         assign w_dvs[k] = req_divisor[8*k +: 8];
      end
   endgenerate

   // Search starts one past the last granted channel and wraps.
   always_comb begin : p_arb
      w_any = 1'b0;
      w_sel = r_ptr;
      w_idx = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_idx = {1'b0, r_ptr} + c_IW'(i);
         if (w_idx >= c_IW'(N_REQ)) begin
            w_idx = w_idx - c_IW'(N_REQ);
         end
         if (!w_any && req[w_idx[c_PW-1:0]]) begin
            w_any = 1'b1;
            w_sel = w_idx[c_PW-1:0];
         end
      end
   end

   assign w_div0     = (r_op_divisor == 8'h00);
   assign w_ovf      = (r_op_dividend == 8'h80) && (r_op_divisor == 8'hFF);
   assign w_wdog_exp = (r_wdog == c_WW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin : p_state
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A zero divisor spends its single RUN cycle without starting the divider.
   always_comb begin : p_next
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = c_ST_RUN;
            end
         end
         c_ST_RUN: begin
            if (w_div0 || div_bus.div_done || w_wdog_exp) begin
               w_state_nxt = c_ST_RESP;
            end
         end
         c_ST_RESP: begin
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   always_comb begin : p_out
      w_gnt_nxt       = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_q_nxt     = r_rsp_q;
      w_rsp_r_nxt     = r_rsp_r;
      w_rsp_err_nxt   = r_rsp_err;
      w_busy_nxt      = r_busy;
      w_start_nxt     = 1'b0;
      w_ld_op         = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = c_ONE << w_sel;
               w_start_nxt = (w_dvs[w_sel] != 8'h00);
               w_busy_nxt  = 1'b1;
               w_ld_op     = 1'b1;
            end
         end
         c_ST_RUN: begin
            w_busy_nxt = 1'b1;
            if (w_div0) begin
               w_rsp_q_nxt   = 8'hFF;
               w_rsp_r_nxt   = r_op_dividend;
               w_rsp_err_nxt = 1'b1;
            end else if (div_bus.div_done) begin
               w_rsp_q_nxt   = div_bus.div_quotient;
               w_rsp_r_nxt   = div_bus.div_remainder;
               w_rsp_err_nxt = w_ovf;
            end else if (w_wdog_exp) begin
               w_rsp_q_nxt   = 8'h00;
               w_rsp_r_nxt   = 8'h00;
               w_rsp_err_nxt = 1'b1;
            end else begin
               w_start_nxt = 1'b1;
            end
            if (w_state_nxt == c_ST_RESP) begin
               w_rsp_valid_nxt = c_ONE << r_ptr;
            end
         end
         c_ST_RESP: begin
            w_busy_nxt = 1'b0;
         end
         default: begin
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         r_gnt         <= '0;
         r_rsp_valid   <= '0;
         r_rsp_q       <= 8'h00;
         r_rsp_r       <= 8'h00;
         r_rsp_err     <= 1'b0;
         r_busy        <= 1'b0;
         r_start       <= 1'b0;
         r_ptr         <= c_PTR_INIT;
         r_wdog        <= '0;
         r_op_dividend <= 8'h00;
         r_op_divisor  <= 8'h00;
      end else begin
         r_gnt       <= w_gnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_q     <= w_rsp_q_nxt;
         r_rsp_r     <= w_rsp_r_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_busy      <= w_busy_nxt;
         r_start     <= w_start_nxt;
         if (w_ld_op) begin
            r_ptr         <= w_sel;
            r_op_dividend <= w_dvd[w_sel];
            r_op_divisor  <= w_dvs[w_sel];
            r_wdog        <= '0;
         end else if (r_state == c_ST_RUN) begin
            r_wdog <= r_wdog + c_WW'(1);
         end
      end
   end

   assign gnt           = r_gnt;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_quotient  = r_rsp_q;
   assign rsp_remainder = r_rsp_r;
   assign rsp_err       = r_rsp_err;
   assign busy          = r_busy;

   assign div_bus.div_start    = r_start;
   assign div_bus.div_dividend = r_op_dividend;
   assign div_bus.div_divisor  = r_op_divisor;

endmodule

`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
// ============================================================================
// Module   : tb_div_share_ctrl
// Purpose  : Self-checking bench for div_share_ctrl with a sequential divider model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_share_ctrl;
   localparam int N  = 4;
   localparam int TO = 15;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_dividend = '0;
   logic [8*N-1:0] req_divisor = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   rsp_valid;
   logic [7:0]     rsp_quotient;
   logic [7:0]     rsp_remainder;
   logic           rsp_err;
   logic           busy;

   div_share_ctrl_if bus ();

   div_share_ctrl #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .div_bus       (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Returns {err, quotient, remainder} for signed 8-bit truncating division.
   function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (b == 8'h00)                   return {1'b1, 8'hFF, a};
      if (a == 8'h80 && b == 8'hFF)     return {1'b1, 8'h80, 8'h00};
      return {1'b0, 8'(sa / sb), 8'(sa % sb)};
   endfunction

   // Divider model: done pulses in the 10th cycle after start is first seen.
   bit          hang = 1'b0;
   logic [7:0]  m_cnt;
   logic [16:0] m_res;
   always_comb m_res = ref_div(bus.div_dividend, bus.div_divisor);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt             <= 8'd0;
         bus.div_done      <= 1'b0;
         bus.div_quotient  <= 8'h00;
         bus.div_remainder <= 8'h00;
      end else begin
         bus.div_done <= 1'b0;
         if (bus.div_start && !bus.div_done) begin
            if (m_cnt == 8'd9 && !hang) begin
               bus.div_done      <= 1'b1;
               bus.div_quotient  <= m_res[15:8];
               bus.div_remainder <= m_res[7:0];
               m_cnt             <= 8'd0;
            end else begin
               m_cnt <= m_cnt + 8'd1;
            end
         end else begin
            m_cnt <= 8'd0;
         end
      end
   end

   typedef struct {
      int          ch;
      logic [16:0] res;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;

   always @(negedge clk) begin
      if (|rsp_valid) begin
         check("rsp_gnt_overlap", gnt, 0);
         check("rsp_busy", busy, 1);
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 0);
         end else begin
            m_e = sb_q.pop_front();
            check("rsp_ch", rsp_valid, 32'd1 << m_e.ch);
            check("rsp_q", rsp_quotient, m_e.res[15:8]);
            check("rsp_r", rsp_remainder, m_e.res[7:0]);
            check("rsp_err", rsp_err, m_e.res[16]);
         end
      end
   end

   task automatic check_zero(input string p);
      check({p, "_gnt"}, gnt, 0);
      check({p, "_rsp_valid"}, rsp_valid, 0);
      check({p, "_q"}, rsp_quotient, 0);
      check({p, "_r"}, rsp_remainder, 0);
      check({p, "_err"}, rsp_err, 0);
      check({p, "_busy"}, busy, 0);
      check({p, "_start"}, bus.div_start, 0);
      check({p, "_dvd"}, bus.div_dividend, 0);
      check({p, "_dvs"}, bus.div_divisor, 0);
   endtask

   task automatic drain(input string p);
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      check({p, "_drain"}, sb_q.size(), 0);
   endtask

   task automatic run_one(input int ch, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee,
                          input int lat, input int exp_starts);
      int t0, starts;
      bit seen;
      @(posedge clk); #1;
      req_dividend[8*ch +: 8] = a;
      req_divisor[8*ch +: 8]  = b;
      req[ch] = 1'b1;
      t0 = cyc;
      starts = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (gnt[ch]) begin
            seen = 1'b1;
            req[ch] = 1'b0;
            sb_q.push_back('{ch: ch, res: {ee, eq, er}});
            check("gnt_latency", cyc - t0, 1);
            check("gnt_onehot", gnt, 32'd1 << ch);
            check("op_dividend", bus.div_dividend, a);
            check("op_divisor", bus.div_divisor, b);
            if (bus.div_start) starts++;
         end
      end
      check("gnt_seen", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.div_start) starts++;
         if (rsp_valid[ch]) begin
            seen = 1'b1;
            check("rsp_latency", cyc - t0, lat);
         end
      end
      check("rsp_seen", seen, 1);
      check("start_cycles", starts, exp_starts);
      @(negedge clk);
      check("busy_after_rsp", busy, 0);
   endtask

   function automatic int next_set(input logic [N-1:0] mask, input int prev);
      for (int i = 1; i <= N; i++) begin
         if (mask[(prev + i) % N]) return (prev + i) % N;
      end
      return -1;
   endfunction

   // Requests held on every channel in mask; grants must rotate 13 cycles apart.
   task automatic held_burst(input logic [N-1:0] mask, input int ngr, input int prev0);
      int t0, last, prev, ng, ec;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         req_dividend[8*k +: 8] = 8'(10 * k + 13);
         req_divisor[8*k +: 8]  = 8'(k + 2);
      end
      req  = mask;
      t0   = cyc;
      last = t0;
      prev = prev0;
      ng   = 0;
      for (int i = 0; i < ngr * 14 + 10 && ng < ngr; i++) begin
         @(negedge clk);
         if (|gnt) begin
            ec = next_set(mask, prev);
            check("burst_gnt", gnt, 32'd1 << ec);
            check("burst_gap", cyc - last, (ng == 0) ? 1 : 13);
            sb_q.push_back('{ch: ec, res: ref_div(8'(10 * ec + 13), 8'(ec + 2))});
            prev = ec;
            last = cyc;
            ng++;
            if (ng == ngr) req = '0;
         end
      end
      req = '0;
      check("burst_count", ng, ngr);
      drain("burst");
   endtask

   typedef struct {
      int         ch;
      logic [7:0] a, b, q, r;
      logic       err;
      int         lat;
      int         starts;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int t0;
      bit seen;

      vecs[0] = '{0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 12, 11};
      vecs[1] = '{1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 12, 11};
      vecs[2] = '{1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 12, 11};
      vecs[3] = '{2, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1,  2,  0};
      vecs[4] = '{3, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 12, 11};
      vecs[5] = '{0, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 12, 11};
      vecs[6] = '{3, 8'h7F, 8'h81, 8'hFF, 8'h00, 1'b0, 12, 11};

      repeat (3) @(negedge clk);
      check_zero("reset");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("post_reset");

      // Channels 0 and 3 together after reset: channel 0 must win.
      held_burst(4'b1001, 1, N - 1);

      foreach (vecs[i]) begin
         run_one(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                 vecs[i].err, vecs[i].lat, vecs[i].starts);
      end
      drain("vectors");

      held_burst(4'b1111, 5, 3);

      hang = 1'b1;
      run_one(1, 8'd50, 8'd5, 8'h00, 8'h00, 1'b1, TO + 1, TO);
      hang = 1'b0;
      run_one(1, 8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 12, 11);
      drain("timeout");

      // Reset during RUN: no response for the aborted transaction.
      @(posedge clk); #1;
      req_dividend[7:0] = 8'd100;
      req_divisor[7:0]  = 8'd7;
      req[0] = 1'b1;
      t0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (gnt[0]) seen = 1'b1;
      end
      req[0] = 1'b0;
      check("abort_gnt_seen", seen, 1);
      while (cyc - t0 < 5) begin
         @(posedge clk); #1;
      end
      check("abort_running", bus.div_start, 1);
      #1 rst_n = 1'b0;
      #1 check_zero("async_reset");
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid, 0);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      run_one(0, 8'd20, 8'd3, 8'h06, 8'h02, 1'b0, 12, 11);
      drain("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule

`default_nettype wire

// File: doc/div_share_ctrl.md
# div_share_ctrl

Round-robin controller that shares one sequential signed 8-bit divider (quotient sign = dividend XOR divisor sign, remainder sign follows dividend) among N requesters. It arbitrates, latches operands, sequences the divider's level-held start / one-cycle done protocol, and returns results on a shared response bus. It handles divide-by-zero and a done-timeout locally. It sits between the requesting datapath blocks and the divider instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 15, cycles in RUN without div_done before error abort (must be ≥ 11)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-channel request level
- req_dividend  in  8*N_REQ  channel k operand at bits [8k+7:8k], signed
- req_divisor  in  8*N_REQ  channel k operand at bits [8k+7:8k], signed
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands accepted
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: response for that channel
- rsp_quotient  out  8  signed quotient, valid with rsp_valid
- rsp_remainder  out  8  signed remainder, valid with rsp_valid
- rsp_err  out  1  divide-by-zero, overflow or timeout, valid with rsp_valid
- busy  out  1  high from grant until the response cycle
- div_start  out  1  divider start level
- div_dividend, div_divisor  out  8 each  operands to divider
- div_done  in  1  divider completion pulse
- div_quotient, div_remainder  in  8 each  divider results

## Operation
- States: IDLE, RUN, RESP.
- IDLE: if any req bit is set, pick the first set bit at or after ptr+1 (mod N_REQ). At the clock edge:
  - pulse gnt[k];
  - latch that channel's operands into op registers, which drive div_dividend/div_divisor and stay stable until the next grant;
  - set ptr = k and busy = 1.
- After the grant:
  - Divisor ≠ 0: set div_start = 1 and go to RUN.
  - Divisor == 0: do not start the divider. Go to RESP with quotient 8'hFF, remainder = dividend and err = 1.
- RUN: hold div_start high. The watchdog counts cycles in RUN.
  - When div_done is sampled high: capture div_quotient/div_remainder. Keep div_start high through this cycle so the divider returns to its idle step, then clear div_start at the edge and go to RESP.
  - err = 1 if the dividend is 8'h80 and the divisor is 8'hFF. The result passes through as q = 8'h80, r = 0.
  - If the watchdog reaches TIMEOUT: clear div_start, go to RESP with q = 0, r = 0 and err = 1.
- RESP: rsp_valid[k] is high for one cycle with the data. busy clears at the end of RESP, then return to IDLE.
- Requests are only evaluated in IDLE. A requester must hold req and its operands until it sees gnt. A req still high after gnt is a new request.
- Only one transaction is in flight at a time.

## Timing
- Reset values:
  - gnt, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, busy, div_start, div_dividend, div_divisor: all 0;
  - ptr = N_REQ-1, so channel 0 has highest priority after reset;
  - state = IDLE.
- Reset mid-operation (any state) forces these values immediately. The divider shares rst_n; no response is issued for the aborted transaction.
- Normal op, with req first sampled in cycle 0:
  - gnt high in cycle 1;
  - div_start high in cycles 1–11;
  - div_done high in cycle 11;
  - rsp_valid high in cycle 12;
  - earliest next gnt in cycle 14.
- Throughput: 13 cycles per division.
- Divide-by-zero: gnt in cycle 1, rsp_valid in cycle 2, div_start never asserted.
- gnt and rsp_valid are registered outputs; they are never high in the same cycle.
- A div_done pulse seen outside RUN is ignored.

## Test plan
- Ch0 100/7, other channels idle → gnt[0] in cycle 1, rsp_valid[0] in cycle 12, q = 14 (8'h0E), r = 2, err = 0; div_start high for exactly 11 cycles.
- Ch1 −100/7 (8'h9C/8'h07) → q = 8'hF2 (−14), r = 8'hFE (−2). Ch1 100/−7 → q = 8'hF2, r = 8'h02.
- All four req high in cycle 0 and held → grants in order 0, 1, 2, 3, then 0, each 13 cycles apart; each rsp_valid one-hot matches its grant; results correct per channel.
- Ch2 55/0 → rsp_valid[2] two cycles after req, q = 8'hFF, r = 8'h37, err = 1; div_start stays 0.
- Ch3 −128/−1 → q = 8'h80, r = 0, err = 1. Divider model that never asserts done → rsp_valid after TIMEOUT, q = r = 0, err = 1, then next request completes normally.
- rst_n low in cycle 5 of RUN → all outputs 0 asynchronously, no rsp_valid. After release, ch0 20/3 → q = 6, r = 2, with latency as above.
